// File: rtl/serial_shift_driver.sv
// ---------------------------------------------------------------------------
// serial_shift_driver
//
// Shifts a parallel frame out MSB-first to a daisy-chained shift-register
// chain (7-segment tubes + LED bar) on a divided serial clock, then pulses
// the latch line and reports completion with a one-cycle done pulse.
//
// Parameters:
//   DATA_WIDTH  frame length in bits (>= 1)
//   CLK_DIV     serial half-period in clk cycles (>= 1)
//
// Ports:
//   clk      in   I/O clock, rising edge
//   rst      in   synchronous active-high reset
//   start    in   frame request, honoured only in IDLE
//   data     in   frame, captured on the accepted start cycle
//   busy     out  high while a frame is in flight (SHIFT_LO..LATCH)
//   done     out  one-cycle completion pulse (first IDLE cycle after LATCH)
//   s_clk    out  serial clock, chain samples on its rising edge
//   s_do     out  serial data, MSB first
//   s_pen    out  latch / parallel-enable pulse, active-high
//   s_clr_n  out  chain clear, active-low, released one cycle after reset
//
// Optional feature macro: SERIAL_AUTO_REFRESH_EN
//   When defined, a done cycle without start automatically recaptures data
//   and starts another frame, giving a continuous refresh.
// ---------------------------------------------------------------------------
module serial_shift_driver #(
  parameter int DATA_WIDTH = 64,
  parameter int CLK_DIV    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic                  s_clk,
  output logic                  s_do,
  output logic                  s_pen,
  output logic                  s_clr_n
);

  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [PW-1:0] PHASE_LOAD = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LOAD   = BW'(DATA_WIDTH - 1);
  localparam logic [PW-1:0] PHASE_ONE  = PW'(1);
  localparam logic [BW-1:0] BIT_ONE    = BW'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  state_t                  state_r;
  logic [DATA_WIDTH-1:0]   shift_r;
  logic [DATA_WIDTH-1:0]   shift_next;
  logic [PW-1:0]           phase_r;
  logic [BW-1:0]           bit_r;
  logic                    go;

  // Next shift-register contents; its MSB is the next bit to present.
  assign shift_next = shift_r << 1;

  // Frame launch condition in IDLE. With auto refresh, the done cycle acts
  // as an implicit start so the chain is refreshed continuously.
`ifdef SERIAL_AUTO_REFRESH_EN
  assign go = start | done;
`else
  assign go = start;
`endif

  // Frame sequencer: state, counters, shift register and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      shift_r <= {DATA_WIDTH{1'b0}};
      phase_r <= {PW{1'b0}};
      bit_r   <= {BW{1'b0}};
      busy    <= 1'b0;
      done    <= 1'b0;
      s_clk   <= 1'b0;
      s_do    <= 1'b0;
      s_pen   <= 1'b0;
      s_clr_n <= 1'b0;
    end else begin
      // Chain clear is released as soon as reset is gone and held released.
      s_clr_n <= 1'b1;
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (go) begin
            shift_r <= data;
            bit_r   <= BIT_LOAD;
            phase_r <= PHASE_LOAD;
            s_do    <= data[DATA_WIDTH-1];
            s_clk   <= 1'b0;
            busy    <= 1'b1;
            state_r <= SHIFT_LO;
          end
        end

        SHIFT_LO: begin
          if (phase_r == {PW{1'b0}}) begin
            phase_r <= PHASE_LOAD;
            s_clk   <= 1'b1;
            state_r <= SHIFT_HI;
          end else begin
            phase_r <= phase_r - PHASE_ONE;
          end
        end

        SHIFT_HI: begin
          if (phase_r == {PW{1'b0}}) begin
            phase_r <= PHASE_LOAD;
            s_clk   <= 1'b0;
            if (bit_r != {BW{1'b0}}) begin
              // s_do changes only here, on the falling s_clk edge, so it is
              // stable for the whole high phase around the rising edge.
              shift_r <= shift_next;
              s_do    <= shift_next[DATA_WIDTH-1];
              bit_r   <= bit_r - BIT_ONE;
              state_r <= SHIFT_LO;
            end else begin
              s_pen   <= 1'b1;
              state_r <= LATCH;
            end
          end else begin
            phase_r <= phase_r - PHASE_ONE;
          end
        end

        LATCH: begin
          if (phase_r == {PW{1'b0}}) begin
            s_pen   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= IDLE;
          end else begin
            phase_r <= phase_r - PHASE_ONE;
          end
        end

        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
          s_clk   <= 1'b0;
          s_pen   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_driver.sv
// ---------------------------------------------------------------------------
// tb_serial_shift_driver
//
// Self-checking bench for serial_shift_driver (W=8, K=3).
// A reference model, clocked on the rising edge, decides which start
// requests are accepted and queues each accepted frame. A monitor on the
// falling edge derives the expected control outputs from the frame timing
// formula, collects s_do on every s_clk rise, and on each done pulse pops
// the queue and compares the collected bit stream with the queued frame.
// Honours SERIAL_AUTO_REFRESH_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_serial_shift_driver;

  localparam int W = 8;
  localparam int K = 3;
  localparam int P = 2 * K * W + K + 1;   // accept edge -> done cycle distance

`ifdef SERIAL_AUTO_REFRESH_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] data  = '0;
  logic         busy, done, s_clk, s_do, s_pen, s_clr_n;

  always #5 clk = ~clk;

  serial_shift_driver #(.DATA_WIDTH(W), .CLK_DIV(K)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .data   (data),
    .busy   (busy),
    .done   (done),
    .s_clk  (s_clk),
    .s_do   (s_do),
    .s_pen  (s_pen),
    .s_clr_n(s_clr_n)
  );

  // model state
  int           cyc      = 0;
  int           e_cur    = 0;
  bit           has_cur  = 1'b0;
  bit           rst_last = 1'b1;
  logic [W-1:0] d_cur    = '0;
  logic [W-1:0] exp_q[$];
  logic         bits_q[$];
  logic         prev_sclk = 1'b0;

  int checks = 0;
  int passes = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, expv);
  endtask

  // reference model: acceptance decisions at each rising edge
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        has_cur  = 1'b0;
        rst_last = 1'b1;
        exp_q.delete();
      end else begin
        rst_last = 1'b0;
        if (!has_cur || (cyc - e_cur >= P)) begin
          if (start || (AUTO && has_cur && (cyc - e_cur == P))) begin
            e_cur   = cyc;
            d_cur   = data;
            has_cur = 1'b1;
            exp_q.push_back(data);
          end
        end
      end
      cyc++;
    end
  end

  // monitor: per-cycle control outputs plus frame scoreboard
  initial begin
    forever begin
      int           t;
      int           bi;
      bit           hi;
      bit           chk_do;
      logic         exp_do;
      logic [4:0]   ev;     // {busy, done, s_clk, s_pen, s_clr_n}
      logic [W-1:0] got;
      logic [W-1:0] want;
      @(negedge clk);
      t      = cyc - e_cur;
      chk_do = 1'b0;
      exp_do = 1'b0;
      if (rst_last) begin
        ev = 5'b00000; chk_do = 1'b1;
      end else if (!has_cur) begin
        ev = 5'b00001; chk_do = 1'b1;
      end else if (t <= 2 * K * W) begin
        bi     = (t - 1) / (2 * K);
        hi     = ((t - 1) % (2 * K)) >= K;
        ev     = {1'b1, 1'b0, hi, 1'b0, 1'b1};
        chk_do = 1'b1;
        exp_do = d_cur[W-1-bi];
      end else if (t <= 2 * K * W + K) begin
        ev = 5'b10011;
      end else if (t == P) begin
        ev = 5'b01001;
      end else begin
        ev = 5'b00001;
      end
      check("ctrl{busy,done,s_clk,s_pen,s_clr_n}", 32'({busy, done, s_clk, s_pen, s_clr_n}), 32'(ev));
      if (chk_do) check("s_do", 32'(s_do), 32'(exp_do));

      if (rst_last) begin
        bits_q.delete();
        prev_sclk = 1'b0;
      end else begin
        if (s_clk && !prev_sclk) bits_q.push_back(s_do);
        prev_sclk = s_clk;
        if (done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'(1), 32'(0));
          end else begin
            want = exp_q.pop_front();
            check("frame_bit_count", 32'(bits_q.size()), 32'(W));
            got = '0;
            for (int i = 0; i < W && i < bits_q.size(); i++) got[W-1-i] = bits_q[i];
            check("frame_bits", 32'(got), 32'(want));
          end
          bits_q.delete();
        end
      end
    end
  end

  // stimulus
  initial begin
    int exp_left;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // plain frame 8'hA5
    start = 1'b1; data = 8'hA5;
    @(negedge clk); start = 1'b0;
    repeat (P + 3) @(negedge clk);

    // frame with data changed in cycle 2 and start re-asserted in cycles 3..10
    start = 1'b1; data = 8'h3C;
    @(negedge clk); start = 1'b0;
    @(negedge clk); data = 8'hC3;
    for (int c = 3; c <= 10; c++) begin
      @(negedge clk); start = 1'b1; data = W'($urandom());
    end
    @(negedge clk); start = 1'b0;
    repeat (P) @(negedge clk);

    // start held high: accepted in each done cycle, back-to-back frames
    start = 1'b1; data = 8'h96;
    repeat (2 * P + 2) @(negedge clk);
    start = 1'b0;
    repeat (P + 2) @(negedge clk);

    // reset asserted in cycle 6 of a frame
    start = 1'b1; data = 8'h5A;
    @(negedge clk); start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (P + 4) @(negedge clk);

    // randomized traffic with occasional resets
    for (int n = 0; n < 2000; n++) begin
      start = ($urandom_range(0, 19) == 0);
      data  = W'($urandom());
      rst   = ($urandom_range(0, 399) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    rst   = 1'b0;
    repeat (P + 5) @(negedge clk);
    #1;
    exp_left = (has_cur && (cyc - e_cur < P)) ? 1 : 0;
    check("queue_drained", 32'(exp_q.size()), 32'(exp_left));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/serial_shift_driver.md
# serial_shift_driver

Serial frame driver between the display controller and the board's daisy-chained shift registers, which feed the 7-segment tubes and the LED bar. It accepts a parallel DATA_WIDTH-bit frame on a start pulse and shifts it out MSB-first on a divided serial clock. After the last bit it pulses the latch line and reports completion. It replaces hand-rolled shift logic in the display path and runs in the low-speed I/O clock domain.

## Interface
- DATA_WIDTH, 64, frame length in bits; must be ≥ 1.
- CLK_DIV, 2, serial half-period in `clk` cycles; must be ≥ 1.

Ports:
- clk  input  1  I/O clock; all logic on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  frame request pulse; sampled only in IDLE.
- data  input  DATA_WIDTH  frame to send; captured on the accepted start cycle.
- busy  output  1  high while a frame is in flight, from SHIFT_LO through LATCH.
- done  output  1  one-cycle completion pulse.
- s_clk  output  1  serial clock to the shift-register chain; data is taken on its rising edge.
- s_do  output  1  serial data, MSB first.
- s_pen  output  1  latch/parallel-enable pulse, active-high.
- s_clr_n  output  1  chain clear, active-low.

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE:
  - start=1 → capture data into the shift register, load the bit counter with DATA_WIDTH-1, load the phase counter with CLK_DIV-1, go to SHIFT_LO.
- SHIFT_LO:
  - s_clk=0; s_do = shift-register MSB.
  - When the phase counter reaches 0 → go to SHIFT_HI and reload the phase counter.
- SHIFT_HI:
  - s_clk=1; s_do is held.
  - When the phase counter reaches 0:
    - If the bit counter ≠ 0 → shift left by one, decrement the bit counter, go to SHIFT_LO.
    - Otherwise → go to LATCH.
- LATCH:
  - s_clk=0, s_pen=1 for CLK_DIV cycles, then go to IDLE.
  - done=1 in the first IDLE cycle after LATCH.
- Other rules:
  - start while busy is ignored: it is not queued and does not affect the frame in flight.
  - Changes on the data input after the capture cycle do not affect the frame in flight.
  - The phase counter is $clog2(CLK_DIV+1) bits wide; the bit counter is $clog2(DATA_WIDTH+1) bits wide.
  - No wrap-around at terminal counts: the state changes exactly when a counter reaches 0.
- All outputs are registered.

## Timing
- Reset values:
  - State IDLE.
  - busy=0, done=0, s_clk=0, s_do=0, s_pen=0, s_clr_n=0.
  - Shift register and counters cleared.
- s_clr_n rises to 1 on the first cycle after rst deasserts and stays at 1 until the next reset.
- Frame timing, with K=CLK_DIV and W=DATA_WIDTH:
  - start is sampled at edge 0.
  - busy=1 and s_do=data[W-1] from cycle 1.
  - Bit i (i=0 is the MSB) is low in cycles 1+2Ki … Ki+K·(i+1) and high for the next K cycles.
  - s_pen=1 in cycles 1+2KW … 2KW+K.
  - done=1 and busy=0 in cycle 1+2KW+K.
- start asserted in the same cycle as done is accepted; the next frame begins in the following cycle.
- Reset mid-frame: the next cycle is IDLE with all outputs at their reset values. No latch pulse and no done are produced.
- s_do is stable for the full K-cycle high phase, so setup/hold at the s_clk rising edge is ≥ K cycles.

## Configuration
- SERIAL_AUTO_REFRESH_EN:
  - When defined: in the done cycle, if start=0, the block automatically captures the current data and enters SHIFT_LO on the next cycle, giving a continuous refresh with period 2KW+K+1 cycles. start still works normally.
  - When undefined: the block stays in IDLE until start is asserted.

## Test plan
- W=8, K=1, data=8'hA5, start pulse:
  - s_do across the 8 rising edges of s_clk reads 1,0,1,0,0,1,0,1.
  - s_pen=1 in cycle 17.
  - done=1 in cycle 18.
- W=64, K=2, data=64'h0123_4567_89AB_CDEF: the 64 sampled bits equal the frame; done appears in cycle 259.
- start re-asserted in cycles 3–10 of a W=8, K=1 frame:
  - Only one frame is sent.
  - Exactly one done pulse.
  - data changed in cycle 2 does not alter the bits sent.
- rst asserted in cycle 6 of a frame:
  - Cycle 7 shows all outputs at their reset values.
  - No s_pen pulse and no done.
  - s_clr_n=1 from the cycle after rst is released.
- SERIAL_AUTO_REFRESH_EN defined, W=8, K=1, one start pulse: done pulses at cycles 18, 36, 54, with an identical bit stream each frame.
